// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane logic: sub-word store merge and load extract/extend.
// Any size other than byte/half is handled as a full word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  size_e       size,
  input  logic [1:0]  byte_sel,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] rdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    merged = word;
    rdata  = word;
    byte_v = word[{byte_sel, 3'b000} +: 8];
    half_v = word[{byte_sel[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        merged[{byte_sel, 3'b000} +: 8] = wdata[7:0];
        rdata = is_unsigned ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        merged[{byte_sel[1], 4'b0000} +: 16] = wdata[15:0];
        rdata = is_unsigned ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit driving a word-wide data memory (async read, sync write).
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 10
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_we,
  input  logic [1:0]                i_req_size,
  input  logic                      i_req_unsigned,
  input  logic [ADDR_WIDTH-1:0]     i_req_addr,
  input  logic [31:0]               i_req_wdata,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [31:0]               o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic                      o_mem_w_en,
  output logic [31:0]               o_mem_din,
  input  logic [31:0]               i_mem_dout
);

  localparam int unsigned LA = MEM_ADDR_WIDTH + 2;

  state_e        state, state_nx;
  logic          r_we, r_unsigned, r_err;
  size_e         r_size;
  logic [LA-1:0] r_addr;
  logic [31:0]   r_wdata, r_rdata, r_merged;
  logic [31:0]   lane_merged, lane_rdata;
  size_e         req_size;
  logic          req_err;
  logic          sub_word;
  logic          accept;
  logic          unused_addr_hi;

  assign req_size       = size_e'(i_req_size);
  assign unused_addr_hi = ^i_req_addr[ADDR_WIDTH-1:LA];
  assign sub_word       = (r_size == SZ_BYTE) || (r_size == SZ_HALF);
  assign accept         = (state == ST_IDLE) && i_req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = (req_size == SZ_RSVD)
                || ((req_size == SZ_HALF) && i_req_addr[0])
                || ((req_size == SZ_WORD) && (i_req_addr[1:0] != 2'b00));
`else
  assign req_err = 1'b0;
`endif

  lsu_byte_lane u_lane (
    .word        (i_mem_dout),
    .wdata       (r_wdata),
    .size        (r_size),
    .byte_sel    (r_addr[1:0]),
    .is_unsigned (r_unsigned),
    .merged      (lane_merged),
    .rdata       (lane_rdata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Write enable is decoded from state so an async reset drops it at once.
  always_comb begin
    state_nx    = state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_mem_w_en  = 1'b0;
    o_mem_din   = '0;
    case (state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_nx = req_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (r_we && !sub_word) begin
          o_mem_w_en = 1'b1;
          o_mem_din  = r_wdata;
          state_nx   = ST_RESP;
        end else if (r_we) begin
          state_nx = ST_WRITE;
        end else begin
          state_nx = ST_RESP;
        end
      end
      ST_WRITE: begin
        o_mem_w_en = 1'b1;
        o_mem_din  = r_merged;
        state_nx   = ST_RESP;
      end
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_merged   <= '0;
      r_err      <= 1'b0;
    end else if (accept) begin
      r_we       <= i_req_we;
      r_unsigned <= i_req_unsigned;
      r_size     <= req_size;
      r_addr     <= i_req_addr[LA-1:0];
      r_wdata    <= i_req_wdata;
      r_rdata    <= '0;
      r_err      <= req_err;
    end else if (state == ST_ACCESS) begin
      if (r_we) r_merged <= lane_merged;
      else      r_rdata  <= lane_rdata;
    end
  end

  assign o_mem_addr  = r_addr[LA-1:2];
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed vector table, back-pressure and reset
// sequences, then random traffic against a byte-array reference memory.
module tb_lsu_mem_port;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'b00;
  logic        i_req_unsigned = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [9:0]  o_mem_addr;
  logic        o_mem_w_en;
  logic [31:0] o_mem_din;
  logic [31:0] i_mem_dout;

  logic [31:0] dut_mem [0:1023];
  logic [7:0]  ref_bytes [0:4095];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  int n_pass = 0;
  int n_total = 0;

  lsu_mem_port #(.ADDR_WIDTH(32), .MEM_ADDR_WIDTH(10)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_addr(o_mem_addr), .o_mem_w_en(o_mem_w_en),
    .o_mem_din(o_mem_din), .i_mem_dout(i_mem_dout)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (bd_we)           dut_mem[bd_addr]    <= bd_data;
    else if (o_mem_w_en) dut_mem[o_mem_addr] <= o_mem_din;
  end
  assign i_mem_dout = dut_mem[o_mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    bd_we = 1'b1; bd_addr = idx[9:0]; bd_data = val;
    for (int b = 0; b < 4; b++) ref_bytes[idx*4 + b] = val[8*b +: 8];
    @(posedge i_clk); #1;
    bd_we = 1'b0;
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[idx*4+3], ref_bytes[idx*4+2], ref_bytes[idx*4+1], ref_bytes[idx*4]};
  endfunction

  // Reference: byte-addressed memory, access width in bytes, cycle counts.
  task automatic model_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic [15:0] wen, output logic [31:0] din, output int widx);
    int n, ba;
    logic [31:0] v;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    err = (size == 2'd3) || (addr % n != 0);
`endif
    ba = int'(addr % 4096) / n * n;
    widx = ba / 4;
    rdata = 0; wen = 0; din = 0; lat = 2;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (32'(ref_bytes[ba+i]) << (8*i));
      if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
      rdata = v;
    end else begin
      for (int i = 0; i < n; i++) ref_bytes[ba+i] = wdata[8*i +: 8];
      din = ref_word(widx);
      lat = (n == 4) ? 2 : 3;
      wen = (n == 4) ? 16'h0002 : 16'h0004;
    end
  endtask

  task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic [15:0] wen, output logic [31:0] din);
    int cyc;
    i_req_valid = 1'b1; i_req_we = we; i_req_size = size;
    i_req_unsigned = uns; i_req_addr = addr; i_req_wdata = wdata;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    cyc = 1; wen = 0; din = 0;
    while (!o_rsp_valid && cyc < 10) begin
      if (o_mem_w_en) begin wen[cyc] = 1'b1; din = o_mem_din; end
      @(posedge i_clk); #1;
      cyc++;
    end
    lat = cyc;
    for (int s = 0; s < stall; s++) begin @(posedge i_clk); #1; end
    rdata = o_rsp_rdata; err = o_rsp_err;
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, rdata;
    logic        err;
    int          lat;
    logic [15:0] wen;
    logic [31:0] din;
  } vec_t;

  function automatic vec_t mk(input string name, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input int lat,
                              input logic [15:0] wen, input logic [31:0] din);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.lat = lat; v.wen = wen; v.din = din;
    return v;
  endfunction

  vec_t tbl [9];

  initial begin
    logic [31:0] rd, md, erd, edin;
    logic        er, eer;
    logic [15:0] wn, ewn;
    int          lt, elt, widx;

    tbl[0] = mk("lw_10",  0, 2'd2, 0, 32'h10, 0, 32'h11223344, 0, 2, 0, 0);
    tbl[1] = mk("lb_17",  0, 2'd0, 0, 32'h17, 0, 32'hFFFFFF80, 0, 2, 0, 0);
    tbl[2] = mk("lbu_17", 0, 2'd0, 1, 32'h17, 0, 32'h00000080, 0, 2, 0, 0);
    tbl[3] = mk("lh_14",  0, 2'd1, 0, 32'h14, 0, 32'h00007F01, 0, 2, 0, 0);
    tbl[4] = mk("lhu_16", 0, 2'd1, 1, 32'h16, 0, 32'h000080FF, 0, 2, 0, 0);
    tbl[5] = mk("lh_16",  0, 2'd1, 0, 32'h16, 0, 32'hFFFF80FF, 0, 2, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[6] = mk("lw_12",  0, 2'd2, 0, 32'h12, 0, 32'h00000000, 1, 1, 0, 0);
`else
    tbl[6] = mk("lw_12",  0, 2'd2, 0, 32'h12, 0, 32'h11223344, 0, 2, 0, 0);
`endif
    tbl[7] = mk("sb_11",  1, 2'd0, 0, 32'h11, 32'h000000AB, 0, 0, 3, 16'h0004, 32'h1122AB44);
    tbl[8] = mk("sw_10",  1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 0, 2, 16'h0002, 32'hDEADBEEF);

    #1 i_rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(o_req_ready), 1);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 0);
    chk("rst_rdata", o_rsp_rdata, 0);
    chk("rst_err", 32'(o_rsp_err), 0);
    chk("rst_mem_addr", 32'(o_mem_addr), 0);
    chk("rst_w_en", 32'(o_mem_w_en), 0);
    chk("rst_din", o_mem_din, 0);

    @(posedge i_clk); #1;
    for (int i = 0; i < 1024; i++) poke(i, $urandom);
    poke(4, 32'h11223344);
    poke(5, 32'h80FF7F01);
    @(negedge i_clk) i_rst = 1'b0;
    @(posedge i_clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, 0, rd, er, lt, wn, md);
      model_op(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
               erd, eer, elt, ewn, edin, widx);
      chk({tbl[i].name, "_lat"}, lt, tbl[i].lat);
      chk({tbl[i].name, "_rdata"}, rd, tbl[i].rdata);
      chk({tbl[i].name, "_err"}, 32'(er), 32'(tbl[i].err));
      chk({tbl[i].name, "_wen"}, 32'(wn), 32'(tbl[i].wen));
      if (tbl[i].we) chk({tbl[i].name, "_din"}, md, tbl[i].din);
    end

    // Back-pressure on a load while a competing request is presented.
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_size = 2'd2; i_req_addr = 32'h14;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 32'h20; i_req_wdata = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      chk("bp_rsp_valid", 32'(o_rsp_valid), 1);
      chk("bp_rdata", o_rsp_rdata, 32'h80FF7F01);
      chk("bp_req_ready", 32'(o_req_ready), 0);
      @(posedge i_clk); #1;
    end
    i_req_valid = 1'b0; i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    chk("bp_after_valid", 32'(o_rsp_valid), 0);
    chk("bp_after_ready", 32'(o_req_ready), 1);
    chk("bp_no_store", dut_mem[8], ref_word(8));

    // Reset asserted in the middle of the WRITE cycle of a halfword store.
    poke(4, 32'h11223344);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'd1; i_req_unsigned = 1'b0;
    i_req_addr = 32'h12; i_req_wdata = 32'h0000BEEF;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("rstw_w_en_before", 32'(o_mem_w_en), 1);
    chk("rstw_din_before", o_mem_din, 32'hBEEF3344);
    #2 i_rst = 1'b1;
    #1;
    chk("rstw_w_en_drop", 32'(o_mem_w_en), 0);
    chk("rstw_rsp_valid", 32'(o_rsp_valid), 0);
    chk("rstw_req_ready", 32'(o_req_ready), 1);
    @(posedge i_clk); #1;
    @(negedge i_clk) i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("rstw_mem_word", dut_mem[4], 32'h11223344);
    chk("rstw_rsp_valid_after", 32'(o_rsp_valid), 0);
    chk("rstw_req_ready_after", 32'(o_req_ready), 1);

    // Random traffic over the full byte address range (upper bits wrap).
    for (int t = 0; t < 300; t++) begin
      logic        we, uns;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom_range(3, 0));
      a = $urandom; wd = $urandom;
      if (t % 3 == 0) a = {a[31:6], 6'h0} | 32'($urandom_range(15, 0));
      run_op(we, sz, uns, a, wd, $urandom_range(2, 0), rd, er, lt, wn, md);
      model_op(we, sz, uns, a, wd, erd, eer, elt, ewn, edin, widx);
      chk("rnd_lat", lt, elt);
      chk("rnd_rdata", rd, erd);
      chk("rnd_err", 32'(er), 32'(eer));
      chk("rnd_wen", 32'(wn), 32'(ewn));
      if (we && !eer) begin
        chk("rnd_din", md, edin);
        chk("rnd_mem", dut_mem[widx], ref_word(widx));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
